soc_test_ctrl: RTL

Synthesizable self-test controller for the rv32ima SoC. It sequences core reset for a programmable number of cycles and snoops the data-bus write port for a riscv-tests style `tohost` store. It reports pass/fail and the failing test number, and enforces an optional cycle-count watchdog. It sits between the board/bench clock-reset source and `rv32ima_soc_top`, and generalises fixed-delay reset release and fixed-time stop into parametrised, data-driven completion.

---
 rtl/soc_test_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/soc_test_ctrl.sv
// rtl/soc_test_ctrl.sv - self-test controller: core reset sequencing, tohost snooping, optional watchdog (SOC_TEST_CTRL_WATCHDOG_EN)
module soc_test_ctrl #(
    parameter int unsigned             ADDR_W          = 32,
    parameter int unsigned             DATA_W          = 32,
    parameter int unsigned             RST_HOLD_CYCLES = 10,
    parameter int unsigned             TIMEOUT_CYCLES  = 50000,
    parameter logic [ADDR_W-1:0]       TOHOST_ADDR     = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              core_rst,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Hold counter counts RST_HOLD_CYCLES-1 down to 0, so HOLD lasts exactly RST_HOLD_CYCLES cycles.
    localparam logic [31:0] HOLD_LOAD = 32'(RST_HOLD_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       hold_cnt_q;
    logic [31:0]       hold_cnt_d;
    logic              core_rst_d;
    logic              done_d;
    logic              pass_d;
    logic [DATA_W-2:0] fail_code_d;
    logic [31:0]       cycle_cnt_d;

    logic              hit;
    logic              data_is_one;
    logic              restart;
    logic              wdog_fire;

    // A tohost hit is a non-zero store to the monitored address; zero stores are benign.
    assign hit         = wr_en && (wr_addr == TOHOST_ADDR) && (wr_data != '0);
    assign data_is_one = (wr_data == DATA_W'(1));
    assign restart     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

`ifdef SOC_TEST_CTRL_WATCHDOG_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic timeout_q;
    logic timeout_d;

    // A hit in the same cycle takes priority, so the watchdog only fires without one.
    assign wdog_fire = (state_q == ST_RUN) && (cycle_cnt == TMO_LAST) && !hit;
    assign timeout   = timeout_q;

    // Watchdog flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    // Watchdog flag next value: cleared on restart, set when the budget runs out.
    always_comb begin
        timeout_d = timeout_q;
        if (restart) begin
            timeout_d = 1'b0;
        end else if (wdog_fire) begin
            timeout_d = 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;

    // TIMEOUT_CYCLES has no effect in this build; RUN ends only on a hit or reset.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_code  <= '0;
            cycle_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            core_rst   <= core_rst_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_code  <= fail_code_d;
            cycle_cnt  <= cycle_cnt_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hit || wdog_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values; core_rst follows the next state so it changes together with it.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        core_rst_d  = (state_d != ST_RUN);
        done_d      = done;
        pass_d      = pass;
        fail_code_d = fail_code;
        cycle_cnt_d = cycle_cnt;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    hold_cnt_d  = HOLD_LOAD;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_code_d = '0;
                    cycle_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 32'd1;
                end
            end
            ST_RUN: begin
                // The hit cycle itself is counted, so cycle_cnt equals RUN cycles spent.
                if (cycle_cnt != 32'hFFFF_FFFF) begin
                    cycle_cnt_d = cycle_cnt + 32'd1;
                end
                if (hit) begin
                    done_d      = 1'b1;
                    pass_d      = data_is_one;
                    fail_code_d = data_is_one ? '0 : wr_data[DATA_W-1:1];
                end else if (wdog_fire) begin
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = '0;
                end
            end
            default: begin
                hold_cnt_d = hold_cnt_q;
            end
        endcase
    end

endmodule
